// File: rtl/spec_power_acc.sv
// Power accumulation datapath and range-bin sequencer for the spectrum accumulator.
// Five-stage free-running pipeline: |X|^2 -> sum -> shift -> addend select -> saturating add.
module spec_power_acc #(
  parameter int FFT_N     = 1024,
  parameter int PWR_SHIFT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fft_dv,
  input  logic [$clog2(FFT_N)-1:0]   fft_index,
  input  logic signed [15:0]         fft_re,
  input  logic signed [15:0]         fft_im,
  input  logic                       pulse_start,
  input  logic [4:0]                 bin_count,
  input  logic                       clear_acc,
  input  logic [31:0]                ram_dout,
  input  logic [31:0]                bg_dout,
  output logic [$clog2(FFT_N)-1:0]   xk_index_reg1,
  output logic [4:0]                 RangeBin_Counter_reg,
  output logic                       data_valid_out,
  output logic [$clog2(FFT_N)-1:0]   data_index,
  output logic [4:0]                 RangeBin_Counter,
  output logic [31:0]                acc_data,
  output logic                       sat_flag,
  output logic                       pulse_done
);
  localparam int IW     = $clog2(FFT_N);
  localparam int STAGES = 4;

  logic [4:0]                     cnt;
  logic                           accept, frame_end;
  logic [STAGES:1]                vld_pipe;
  logic [STAGES:1][IW-1:0]        idx_pipe;
  logic [STAGES:1][4:0]           bin_pipe;
  logic signed [31:0]             re_p, im_p;
  logic [30:0]                    re_sq, im_sq;
  logic [31:0]                    pwr_sum, pwr_sh, pwr4;
  logic [31:0]                    addend;
  logic [32:0]                    sum33;
  logic                           last5;

  assign accept    = fft_dv && (cnt != 5'd0);
  assign frame_end = accept && (fft_index == IW'(FFT_N-1));

  // pulse_start outranks a coincident frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= 5'd0;
    else if (pulse_start)   cnt <= 5'd1;
    else if (frame_end)     cnt <= (cnt < bin_count) ? cnt + 5'd1 : 5'd0;
  end

  // Tags ride along with the data; bin reads 0 on empty slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
      bin_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      idx_pipe <= {idx_pipe[STAGES-1:1], fft_index};
      bin_pipe <= {bin_pipe[STAGES-1:1], (accept ? cnt : 5'd0)};
    end
  end

  assign re_p = fft_re * fft_re;
  assign im_p = fft_im * fft_im;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_sq   <= '0;
      im_sq   <= '0;
      pwr_sum <= '0;
      pwr_sh  <= '0;
      pwr4    <= '0;
    end else begin
      re_sq   <= re_p[30:0];
      im_sq   <= im_p[30:0];
      pwr_sum <= {1'b0, re_sq} + {1'b0, im_sq};
      pwr_sh  <= pwr_sum >> PWR_SHIFT;
      pwr4    <= pwr_sh;
    end
  end

  // Bin 1 accumulates into the background RAM
  always_comb begin
    addend = ram_dout;
    if (clear_acc)                   addend = 32'd0;
    else if (bin_pipe[STAGES] == 5'd1) addend = bg_dout;
  end

  assign sum33 = {1'b0, addend} + {1'b0, pwr4};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data   <= '0;
      sat_flag   <= 1'b0;
      last5      <= 1'b0;
      pulse_done <= 1'b0;
    end else begin
      if (vld_pipe[STAGES])
        acc_data <= sum33[32] ? 32'hFFFF_FFFF : sum33[31:0];
      if (pulse_start)
        sat_flag <= 1'b0;
      else if (vld_pipe[STAGES] && sum33[32])
        sat_flag <= 1'b1;
      last5      <= vld_pipe[STAGES] && (idx_pipe[STAGES] == IW'(FFT_N-1)) &&
                    (bin_pipe[STAGES] == bin_count);
      pulse_done <= last5;
    end
  end

  assign xk_index_reg1        = idx_pipe[1];
  assign RangeBin_Counter_reg = bin_pipe[1];
  assign data_valid_out       = vld_pipe[STAGES];
  assign data_index           = idx_pipe[STAGES];
  assign RangeBin_Counter     = bin_pipe[STAGES];
endmodule
